tile_mem_sched: RTL



---
 rtl/tile_sched_pkg.sv | 15 +
 rtl/rr_arbiter3.sv | 48 ++++
 rtl/tile_mem_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tile operand-memory scheduler.
package tile_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd2,
    ST_EXEC     = 2'd3
  } sched_state_e;

  localparam int NUM_REQ  = 3;
  localparam int REQ_NBR1 = 0;
  localparam int REQ_NBR2 = 1;
  localparam int REQ_CFG  = 2;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin picker: combinational one-hot pick starting at the
// pointer, pointer moves past the served requester on an advance strobe.
module rr_arbiter3
  import tile_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  input  logic [NUM_REQ-1:0] adv_gnt,
  output logic [NUM_REQ-1:0] pick
);

  logic [1:0]         ptr_q;
  logic [NUM_REQ-1:0] rot;
  logic [NUM_REQ-1:0] pri;

  // Rotate so the pointer position lands on bit 0, pick lowest, rotate back.
  always_comb begin
    rot  = req;
    pick = '0;
    case (ptr_q)
      2'd1:    rot = {req[0], req[2:1]};
      2'd2:    rot = {req[1:0], req[2]};
      default: rot = req;
    endcase
    if (rot[0])      pri = 3'b001;
    else if (rot[1]) pri = 3'b010;
    else if (rot[2]) pri = 3'b100;
    else             pri = 3'b000;
    case (ptr_q)
      2'd1:    pick = {pri[1], pri[0], pri[2]};
      2'd2:    pick = {pri[0], pri[2], pri[1]};
      default: pick = pri;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 2'd0;
    end else if (adv) begin
      if (adv_gnt[REQ_NBR1])      ptr_q <= 2'd1;
      else if (adv_gnt[REQ_NBR2]) ptr_q <= 2'd2;
      else                        ptr_q <= 2'd0;
    end
  end

endmodule

// File: rtl/tile_mem_sched.sv
// Operand-memory sequencer: arbitrates the three write ports and runs fixed
// execution windows, never overlapping on_off with a write. Option: TILE_SCHED_TIMEOUT_EN.
module tile_mem_sched
  import tile_sched_pkg::*;
#(
  parameter int EXEC_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       start,
  input  logic       write_ack,
  output logic       write_en1,
  output logic       write_en2,
  output logic       write_en3,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic       on_off,
  output logic       exec_busy,
  output logic [1:0] phase,
  output logic [2:0] err
);

  localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

  sched_state_e       state_q, state_d;
  logic [2:0]         gnt_q, gnt_d;
  logic [2:0]         done_q, done_d;
  logic [2:0]         err_q, err_d;
  logic               on_q, on_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] pick;
  logic               adv;

`ifdef TILE_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  rr_arbiter3 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .adv     (adv),
    .adv_gnt (gnt_q),
    .pick    (pick)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = err_q;
    on_d    = on_q;
    cnt_d   = cnt_q;
    adv     = 1'b0;
`ifdef TILE_SCHED_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Pending writes always take precedence over an execution request.
        if (req != 3'b000) begin
          state_d = ST_WAIT_ACK;
          gnt_d   = pick;
`ifdef TILE_SCHED_TIMEOUT_EN
          to_d    = '0;
`endif
        end else if (start) begin
          state_d = ST_EXEC;
          on_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (write_ack) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          done_d  = gnt_q;
          adv     = 1'b1;
        end
`ifdef TILE_SCHED_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          err_d   = err_q | gnt_q;
          adv     = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      ST_EXEC: begin
        if (cnt_q == CNT_W'(EXEC_CYCLES - 1)) begin
          state_d = ST_IDLE;
          on_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        on_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      on_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef TILE_SCHED_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      on_q    <= on_d;
      cnt_q   <= cnt_d;
`ifdef TILE_SCHED_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  // Write enables come straight from the grant flops, on_off only from EXEC,
  // so the two can never be high together.
  assign write_en1 = gnt_q[REQ_NBR1];
  assign write_en2 = gnt_q[REQ_NBR2];
  assign write_en3 = gnt_q[REQ_CFG];
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign on_off    = on_q;
  assign exec_busy = on_q;
  assign phase     = state_q;
  assign err       = err_q;

endmodule
